// File: rtl/ray_pkg.sv
// Shared types and default widths for the ray dispatch front end.
package ray_pkg;

    localparam int DEFAULT_POSITION_WIDTH = 16;
    localparam int DEFAULT_ADDRESS_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } dispatch_state_t;

    // Three-component vector, x in the least significant bits.
    typedef struct packed {
        logic [DEFAULT_POSITION_WIDTH-1:0] z;
        logic [DEFAULT_POSITION_WIDTH-1:0] y;
        logic [DEFAULT_POSITION_WIDTH-1:0] x;
    } position_t;

endpackage

// File: rtl/round_robin_picker.sv
// Picks the first requesting unit at or after the pointer, wrapping around.
module round_robin_picker #(
    parameter int NUM_UNITS     = 4,
    parameter int POINTER_WIDTH = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [NUM_UNITS-1:0]     request,
    input  logic [POINTER_WIDTH-1:0] pointer,
    output logic [NUM_UNITS-1:0]     grant,
    output logic                     valid
);

    logic [NUM_UNITS-1:0] masked;

    // Prefer requests at or above the pointer; fall back to the lowest request overall.
    always_comb begin
        masked = '0;
        grant  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            masked[i] = request[i] && (i >= int'(pointer));
        end
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (request[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        if (masked != '0) begin
            for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                if (masked[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
        valid = (request != '0);
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Walks a frame pixel by pixel and hands each primary ray to a free ray unit.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int POSITION_WIDTH = DEFAULT_POSITION_WIDTH,
    parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int NUM_UNITS      = 4,
    parameter int DIM_WIDTH      = 10,
    parameter int PIXEL_BYTES    = 4
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          frameStart,
    input  logic [DIM_WIDTH-1:0]                          width,
    input  logic [DIM_WIDTH-1:0]                          height,
    input  logic [ADDRESS_WIDTH-1:0]                      frameAddress,
    input  logic [3*POSITION_WIDTH-1:0]                   cameraQ,
    input  logic [3*POSITION_WIDTH-1:0]                   dirOrigin,
    input  logic [3*POSITION_WIDTH-1:0]                   dirStepX,
    input  logic [3*POSITION_WIDTH-1:0]                   dirStepY,
    input  logic [NUM_UNITS-1:0]                          unitBusy,
    output logic [NUM_UNITS-1:0]                          unitStart,
    output logic [3*POSITION_WIDTH-1:0]                   rayQ,
    output logic [NUM_UNITS-1:0][3*POSITION_WIDTH-1:0]    rayV,
    output logic [NUM_UNITS-1:0][ADDRESS_WIDTH-1:0]       pixelAddress,
    output logic                                          frameBusy,
    output logic                                          frameDone
);

    localparam int POINTER_WIDTH = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int VW            = 3 * POSITION_WIDTH;

    dispatch_state_t state, state_next;

    logic [DIM_WIDTH-1:0]     x, y, width_r, height_r;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [VW-1:0]            cur_v, row_v, step_x, step_y;
    logic [POINTER_WIDTH-1:0] pointer, grant_index;
    logic [NUM_UNITS-1:0]     request, grant;
    logic                     grant_valid, issue, start_frame, done_next;
    logic                     row_end, last_pixel;

    function automatic logic [VW-1:0] vec_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int c = 0; c < 3; c++) begin
            r[c*POSITION_WIDTH +: POSITION_WIDTH] =
                a[c*POSITION_WIDTH +: POSITION_WIDTH] + b[c*POSITION_WIDTH +: POSITION_WIDTH];
        end
        return r;
    endfunction

    // A unit pulsed last cycle has not raised busy yet, so it counts as taken.
    assign request    = ~unitBusy & ~unitStart;
    assign row_end    = (x == width_r - DIM_WIDTH'(1));
    assign last_pixel = row_end && (y == height_r - DIM_WIDTH'(1));
    assign frameBusy  = (state != IDLE);

    round_robin_picker #(
        .NUM_UNITS     (NUM_UNITS),
        .POINTER_WIDTH (POINTER_WIDTH)
    ) picker (
        .request (request),
        .pointer (pointer),
        .grant   (grant),
        .valid   (grant_valid)
    );

    always_comb begin
        grant_index = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) grant_index = POINTER_WIDTH'(i);
        end
    end

    always_comb begin
        state_next  = state;
        done_next   = 1'b0;
        issue       = 1'b0;
        start_frame = 1'b0;
        unique case (state)
            IDLE: begin
                if (frameStart) begin
                    if (width != '0 && height != '0) begin
                        start_frame = 1'b1;
                        state_next  = DISPATCH;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            DISPATCH: begin
                if (grant_valid) begin
                    issue = 1'b1;
                    if (last_pixel) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (unitBusy == '0 && unitStart == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // At a row end the next row starts from the row base advanced by one y step.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            unitStart    <= '0;
            frameDone    <= 1'b0;
            pointer      <= '0;
            x            <= '0;
            y            <= '0;
            width_r      <= '0;
            height_r     <= '0;
            addr         <= '0;
            cur_v        <= '0;
            row_v        <= '0;
            step_x       <= '0;
            step_y       <= '0;
            rayQ         <= '0;
            rayV         <= '0;
            pixelAddress <= '0;
        end else begin
            state     <= state_next;
            frameDone <= done_next;
            unitStart <= issue ? grant : '0;
            if (start_frame) begin
                width_r  <= width;
                height_r <= height;
                rayQ     <= cameraQ;
                step_x   <= dirStepX;
                step_y   <= dirStepY;
                cur_v    <= dirOrigin;
                row_v    <= dirOrigin;
                addr     <= frameAddress;
                x        <= '0;
                y        <= '0;
            end
            if (issue) begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (grant[i]) begin
                        rayV[i]         <= cur_v;
                        pixelAddress[i] <= addr;
                    end
                end
                pointer <= (grant_index == POINTER_WIDTH'(NUM_UNITS - 1)) ? '0 : grant_index + POINTER_WIDTH'(1);
                addr    <= addr + ADDRESS_WIDTH'(PIXEL_BYTES);
                if (row_end) begin
                    x     <= '0;
                    y     <= y + DIM_WIDTH'(1);
                    row_v <= vec_add(row_v, step_y);
                    cur_v <= vec_add(row_v, step_y);
                end else begin
                    x     <= x + DIM_WIDTH'(1);
                    cur_v <= vec_add(cur_v, step_x);
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher with a pixel-order reference model checked every cycle.
module tb_ray_dispatcher;
    import ray_pkg::*;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int NU = 4;
    localparam int DW = 10;
    localparam int PB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frameStart = 1'b0;
    logic [DW-1:0] width = '0, height = '0;
    logic [AW-1:0] frameAddress = '0;
    logic [3*PW-1:0] cameraQ = '0, dirOrigin = '0, dirStepX = '0, dirStepY = '0;
    logic [NU-1:0] unitBusy = '0;
    logic [NU-1:0] unitStart;
    logic [3*PW-1:0] rayQ;
    logic [NU-1:0][3*PW-1:0] rayV;
    logic [NU-1:0][AW-1:0] pixelAddress;
    logic frameBusy, frameDone;

    int checks = 0;
    int errors = 0;

    ray_dispatcher #(
        .POSITION_WIDTH (PW), .ADDRESS_WIDTH (AW), .NUM_UNITS (NU),
        .DIM_WIDTH (DW), .PIXEL_BYTES (PB)
    ) dut (
        .clock (clock), .reset (reset), .frameStart (frameStart),
        .width (width), .height (height), .frameAddress (frameAddress),
        .cameraQ (cameraQ), .dirOrigin (dirOrigin), .dirStepX (dirStepX), .dirStepY (dirStepY),
        .unitBusy (unitBusy), .unitStart (unitStart), .rayQ (rayQ), .rayV (rayV),
        .pixelAddress (pixelAddress), .frameBusy (frameBusy), .frameDone (frameDone)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Direction of pixel (px,py) straight from origin + px*stepX + py*stepY, per component.
    function automatic logic [3*PW-1:0] expected_dir(input logic [3*PW-1:0] o, input logic [3*PW-1:0] sx,
                                                     input logic [3*PW-1:0] sy, input int px, input int py);
        logic [3*PW-1:0] r;
        for (int c = 0; c < 3; c++) begin
            int sum;
            sum = int'(o[c*PW +: PW]) + int'(sx[c*PW +: PW]) * px + int'(sy[c*PW +: PW]) * py;
            r[c*PW +: PW] = sum[PW-1:0];
        end
        return r;
    endfunction

    int              log_unit[$];
    logic [AW-1:0]   log_addr[$];
    logic [3*PW-1:0] log_v[$];
    int              log_cycle[$];
    int done_count = 0, done_cycle = 0, cycle = 0;

    bit              m_active = 1'b0;
    int              m_k = 0, m_total = 0, m_w = 1, m_ptr = 0;
    logic [AW-1:0]   m_base = '0;
    logic [3*PW-1:0] m_cam = '0, m_o = '0, m_sx = '0, m_sy = '0;
    logic [NU-1:0]   m_prev_start = '0;

    logic            p_reset = 1'b1, p_fs = 1'b0;
    logic [DW-1:0]   p_w = '0, p_h = '0;
    logic [AW-1:0]   p_addr = '0;
    logic [3*PW-1:0] p_cam = '0, p_o = '0, p_sx = '0, p_sy = '0;
    logic [NU-1:0]   p_busy = '0;

    // Compare process: p_* hold the inputs the DUT saw at the edge just before this negedge.
    always @(negedge clock) begin
        logic [NU-1:0]   exp_start, avail;
        logic            exp_done;
        logic [3*PW-1:0] got_v;
        logic [AW-1:0]   got_a;
        int              u, idx;
        cycle++;
        exp_start = '0;
        exp_done  = 1'b0;
        u         = -1;
        if (p_reset) begin
            m_active = 1'b0;
            m_ptr    = 0;
            check_output("reset_unitStart", unitStart, 0);
            check_output("reset_frameDone", frameDone, 0);
            check_output("reset_frameBusy", frameBusy, 0);
            check_output("reset_rayQ", rayQ, 0);
            for (int j = 0; j < NU; j++) begin
                check_output("reset_rayV", rayV[j], 0);
                check_output("reset_pixelAddress", pixelAddress[j], 0);
            end
        end else begin
            if (!m_active) begin
                if (p_fs) begin
                    if (p_w == 0 || p_h == 0) begin
                        exp_done = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_k = 0;
                        m_w = int'(p_w);
                        m_total = int'(p_w) * int'(p_h);
                        m_base = p_addr; m_cam = p_cam; m_o = p_o; m_sx = p_sx; m_sy = p_sy;
                    end
                end
            end else if (m_k == m_total) begin
                if (p_busy == '0 && m_prev_start == '0) begin
                    exp_done = 1'b1;
                    m_active = 1'b0;
                end
            end else begin
                avail = ~p_busy & ~m_prev_start;
                for (int off = 0; off < NU; off++) begin
                    idx = (m_ptr + off) % NU;
                    if (u < 0 && ((avail >> idx) & NU'(1)) != '0) u = idx;
                end
                if (u >= 0) begin
                    exp_start = NU'(1) << u;
                    m_ptr = (u + 1) % NU;
                end
            end
            check_output("unitStart", unitStart, exp_start);
            check_output("frameDone", frameDone, exp_done);
            if (u >= 0) begin
                got_v = '0;
                got_a = '0;
                for (int j = 0; j < NU; j++) begin
                    if (j == u) begin
                        got_v = rayV[j];
                        got_a = pixelAddress[j];
                    end
                end
                check_output("rayV", got_v, expected_dir(m_o, m_sx, m_sy, m_k % m_w, m_k / m_w));
                check_output("pixelAddress", got_a, m_base + AW'(PB * m_k));
                log_unit.push_back(u);
                log_addr.push_back(got_a);
                log_v.push_back(got_v);
                log_cycle.push_back(cycle);
                m_k++;
            end
            check_output("frameBusy", frameBusy, m_active);
            if (m_active) check_output("rayQ", rayQ, m_cam);
            if (frameDone === 1'b1) begin
                done_count++;
                done_cycle = cycle;
            end
        end
        m_prev_start = exp_start;
        p_reset = reset; p_fs = frameStart; p_w = width; p_h = height; p_addr = frameAddress;
        p_cam = cameraQ; p_o = dirOrigin; p_sx = dirStepX; p_sy = dirStepY; p_busy = unitBusy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log_unit.delete(); log_addr.delete(); log_v.delete(); log_cycle.delete();
    endtask

    task automatic start_frame(input int w, input int h, input logic [AW-1:0] a, input logic [3*PW-1:0] cam,
                               input logic [3*PW-1:0] o, input logic [3*PW-1:0] sx, input logic [3*PW-1:0] sy);
        width = DW'(w); height = DW'(h); frameAddress = a;
        cameraQ = cam; dirOrigin = o; dirStepX = sx; dirStepY = sy;
        frameStart = 1'b1;
        tick(1);
        frameStart = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check_output(name, done_count >= target, 1);
    endtask

    task automatic wait_log(input int count, input int budget, input string name);
        int n = 0;
        while (log_unit.size() < count && n < budget) begin
            tick(1);
            n++;
        end
        check_output(name, log_unit.size() >= count, 1);
    endtask

    initial begin
        logic [3*PW-1:0] exp27 [6];
        int d0, c0, n0;
        exp27 = '{ {16'h0100, 16'h0000, 16'h0000}, {16'h0100, 16'h0000, 16'h0001},
                   {16'h0100, 16'h0000, 16'h0002}, {16'h0100, 16'h0001, 16'h0000},
                   {16'h0100, 16'h0001, 16'h0001}, {16'h0100, 16'h0001, 16'h0002} };

        tick(3);
        reset = 1'b0;
        tick(1);
        check_output("idle_frameBusy", frameBusy, 0);

        // 2x2 frame, all units idle: four starts on units 0..3 in consecutive cycles
        clear_logs();
        d0 = done_count;
        start_frame(2, 2, 32'h1000, {16'h0003, 16'h0002, 16'h0001}, '0, '0, '0);
        wait_done(d0 + 1, 50, "t1_done");
        check_output("t1_count", log_unit.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_output("t1_unit", log_unit[i], i);
            check_output("t1_addr", log_addr[i], 32'h1000 + 32'(4 * i));
            check_output("t1_cycle", log_cycle[i] - log_cycle[0], i);
        end
        check_output("t1_done_after_last", done_cycle > log_cycle[3], 1);

        // 3x2 direction walk
        clear_logs();
        d0 = done_count;
        start_frame(3, 2, 32'h0, '0, {16'h0100, 16'h0000, 16'h0000},
                    {16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0001, 16'h0000});
        wait_done(d0 + 1, 60, "t2_done");
        check_output("t2_count", log_v.size(), 6);
        for (int i = 0; i < 6; i++) check_output("t2_rayV", log_v[i], exp27[i]);

        // Pointer now 2 with unit 2 busy: the single pixel goes to unit 3
        clear_logs();
        unitBusy = 4'b0100;
        d0 = done_count;
        start_frame(1, 1, 32'h3000, '0, '0, '0, '0);
        wait_log(1, 20, "t3_issue");
        unitBusy = 4'b1100;
        tick(6);
        check_output("t3_no_early_done", done_count, d0);
        check_output("t3_unit", log_unit[0], 3);
        unitBusy = 4'b0000;
        wait_done(d0 + 1, 20, "t3_done");

        // All units busy for 10 cycles mid-frame: dispatch stalls then resumes in order
        clear_logs();
        d0 = done_count;
        start_frame(4, 2, 32'h2000, '0, {16'h0000, 16'h0000, 16'h0010},
                    {16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0001, 16'h0000});
        wait_log(3, 20, "t4_first");
        unitBusy = 4'b1111;
        tick(1);
        n0 = log_unit.size();
        tick(10);
        check_output("t4_stall", log_unit.size(), n0);
        unitBusy = 4'b0000;
        wait_done(d0 + 1, 60, "t4_done");
        check_output("t4_count", log_unit.size(), 8);
        check_output("t4_resume_addr", log_addr[n0], 32'h2000 + 32'(4 * n0));
        check_output("t4_gap", log_cycle[n0] - log_cycle[n0-1] >= 11, 1);

        // Direction x wraps from 0xFFFF to 0x0000
        clear_logs();
        d0 = done_count;
        start_frame(2, 1, 32'h0, '0, {16'h0000, 16'h0000, 16'hFFFF},
                    {16'h0000, 16'h0000, 16'h0001}, '0);
        wait_done(d0 + 1, 30, "t5_done");
        check_output("t5_first_x", log_v[0][15:0], 16'hFFFF);
        check_output("t5_wrap_x", log_v[1][15:0], 16'h0000);

        // Zero-width frame completes immediately with no ray
        clear_logs();
        d0 = done_count;
        start_frame(0, 3, 32'h0, '0, '0, '0, '0);
        c0 = cycle;
        tick(3);
        check_output("t6_done_count", done_count, d0 + 1);
        check_output("t6_done_cycle", done_cycle, c0 + 1);
        check_output("t6_no_start", log_unit.size(), 0);

        // Reset in the middle of a large frame abandons it silently
        clear_logs();
        d0 = done_count;
        start_frame(8, 8, 32'h4000, '0, '0, '0, '0);
        wait_log(3, 20, "t7_first");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        check_output("t7_idle", frameBusy, 0);
        tick(5);
        check_output("t7_no_done", done_count, d0);
        check_output("t7_no_start", unitStart, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
